// File: rtl/axi_wr_rr_arbiter.sv
// Round-robin arbiter sharing one AXI write path (AW/W/B) among NUM_M requesters.
// A grant covers the whole write; WLAST is regenerated from a beat counter and mismatches flagged.
module axi_wr_rr_arbiter #(
  parameter int unsigned NUM_M  = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 4
) (
  input  logic                          ACLK,
  input  logic                          ARESETn,
  input  logic [NUM_M-1:0]              s_awvalid,
  input  logic [NUM_M*ADDR_W-1:0]       s_awaddr,
  input  logic [NUM_M*LEN_W-1:0]        s_awlen,
  input  logic [NUM_M*2-1:0]            s_awburst,
  output logic [NUM_M-1:0]              s_awready,
  input  logic [NUM_M-1:0]              s_wvalid,
  input  logic [NUM_M*DATA_W-1:0]       s_wdata,
  input  logic [NUM_M*DATA_W/8-1:0]     s_wstrb,
  input  logic [NUM_M-1:0]              s_wlast,
  output logic [NUM_M-1:0]              s_wready,
  output logic [NUM_M-1:0]              s_bvalid,
  output logic [1:0]                    s_bresp,
  output logic [3:0]                    s_bid,
  input  logic [NUM_M-1:0]              s_bready,
  output logic                          m_awvalid,
  output logic [ADDR_W-1:0]             m_awaddr,
  output logic [LEN_W-1:0]              m_awlen,
  output logic [1:0]                    m_awburst,
  input  logic                          m_awready,
  output logic                          m_wvalid,
  output logic [DATA_W-1:0]             m_wdata,
  output logic [DATA_W/8-1:0]           m_wstrb,
  output logic                          m_wlast,
  input  logic                          m_wready,
  input  logic                          m_bvalid,
  input  logic [1:0]                    m_bresp,
  input  logic [3:0]                    m_bid,
  output logic                          m_bready,
  output logic [$clog2(NUM_M)-1:0]      grant_idx,
  output logic                          busy,
  output logic [NUM_M-1:0]              err_wlast
);

  localparam int unsigned IdxW  = $clog2(NUM_M);
  localparam int unsigned StrbW = DATA_W / 8;

  typedef enum logic [1:0] {StIdle, StAddr, StData, StResp} state_e;

  state_e           state_q, state_d;
  logic [IdxW-1:0]  rr_q, rr_d;
  logic [IdxW-1:0]  grant_q, grant_d;
  logic [LEN_W-1:0] beat_q, beat_d;
  logic [NUM_M-1:0] err_q, err_d;

  logic             arb_found;
  logic [IdxW-1:0]  arb_idx;
  logic [IdxW-1:0]  cand;
  logic             aw_hs, w_hs, b_hs;

  // Cyclic search starting just after the last owner.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_M; k++) begin
      cand = IdxW'((32'(rr_q) + k) % NUM_M);
      if (!arb_found && s_awvalid[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  assign m_awaddr  = s_awaddr[grant_q*ADDR_W +: ADDR_W];
  assign m_awlen   = s_awlen[grant_q*LEN_W +: LEN_W];
  assign m_awburst = s_awburst[grant_q*2 +: 2];
  assign m_wdata   = s_wdata[grant_q*DATA_W +: DATA_W];
  assign m_wstrb   = s_wstrb[grant_q*StrbW +: StrbW];
  assign s_bresp   = m_bresp;
  assign s_bid     = m_bid;
  assign grant_idx = grant_q;
  assign busy      = (state_q != StIdle);
  assign err_wlast = err_q;

  always_comb begin
    m_awvalid = 1'b0;
    m_wvalid  = 1'b0;
    m_wlast   = 1'b0;
    m_bready  = 1'b0;
    s_awready = '0;
    s_wready  = '0;
    s_bvalid  = '0;
    unique case (state_q)
      StAddr: begin
        m_awvalid          = s_awvalid[grant_q];
        s_awready[grant_q] = m_awready;
      end
      StData: begin
        m_wvalid          = s_wvalid[grant_q];
        m_wlast           = (beat_q == '0);
        s_wready[grant_q] = m_wready;
      end
      StResp: begin
        m_bready          = s_bready[grant_q];
        s_bvalid[grant_q] = m_bvalid;
      end
      default: ;
    endcase
  end

  assign aw_hs = m_awvalid & m_awready;
  assign w_hs  = m_wvalid & m_wready;
  assign b_hs  = m_bvalid & m_bready;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    beat_d  = beat_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (arb_found) begin
          grant_d = arb_idx;
          state_d = StAddr;
        end
      end
      StAddr: begin
        if (aw_hs) begin
          beat_d  = m_awlen;
          state_d = StData;
        end
      end
      StData: begin
        if (w_hs) begin
          if (s_wlast[grant_q] != m_wlast) err_d[grant_q] = 1'b1;
          if (beat_q == '0) state_d = StResp;
          else              beat_d  = beat_q - 1'b1;
        end
      end
      StResp: begin
        if (b_hs) begin
          rr_d    = grant_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= StIdle;
      rr_q    <= IdxW'(NUM_M - 1);
      grant_q <= '0;
      beat_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_axi_wr_rr_arbiter.sv
// Randomized bench for axi_wr_rr_arbiter against a transaction-level model of
// ownership, round-robin order, beat accounting and sticky WLAST errors.
module tb_axi_wr_rr_arbiter;

  localparam int unsigned NUM_M  = 4;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LEN_W  = 4;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned IDX_W  = $clog2(NUM_M);
  localparam int          NCYC   = 4000;

  logic                      ACLK, ARESETn;
  logic [NUM_M-1:0]          s_awvalid, s_awready, s_wvalid, s_wlast, s_wready;
  logic [NUM_M-1:0]          s_bvalid, s_bready, err_wlast;
  logic [NUM_M*ADDR_W-1:0]   s_awaddr;
  logic [NUM_M*LEN_W-1:0]    s_awlen;
  logic [NUM_M*2-1:0]        s_awburst;
  logic [NUM_M*DATA_W-1:0]   s_wdata;
  logic [NUM_M*STRB_W-1:0]   s_wstrb;
  logic [1:0]                s_bresp, m_awburst, m_bresp;
  logic [3:0]                s_bid, m_bid;
  logic                      m_awvalid, m_awready, m_wvalid, m_wlast, m_wready;
  logic                      m_bvalid, m_bready, busy;
  logic [ADDR_W-1:0]         m_awaddr;
  logic [LEN_W-1:0]          m_awlen;
  logic [DATA_W-1:0]         m_wdata;
  logic [STRB_W-1:0]         m_wstrb;
  logic [IDX_W-1:0]          grant_idx;

  axi_wr_rr_arbiter #(
    .NUM_M(NUM_M), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awburst(s_awburst),
    .s_awready(s_awready),
    .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_wready(s_wready),
    .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bid(s_bid), .s_bready(s_bready),
    .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awburst(m_awburst),
    .m_awready(m_awready),
    .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bid(m_bid), .m_bready(m_bready),
    .grant_idx(grant_idx), .busy(busy), .err_wlast(err_wlast)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Requester-side transaction records.
  bit          has_txn [NUM_M];
  bit          aw_done [NUM_M];
  int unsigned len_r   [NUM_M];
  int unsigned sent    [NUM_M];
  int          bad_beat[NUM_M];
  logic [31:0] addr_r  [NUM_M];
  logic [31:0] base_r  [NUM_M];
  logic [1:0]  burst_r [NUM_M];

  // Model: owner (-1 = none), phase 0=address 1=data 2=response, last owner.
  int               own;
  int               ph;
  int               rr;
  logic [NUM_M-1:0] exp_err;
  bit               force_all;
  bit               after_rst;

  task automatic new_txn(input int i);
    has_txn[i]  = 1'b1;
    aw_done[i]  = 1'b0;
    sent[i]     = 0;
    len_r[i]    = ($urandom_range(0, 7) == 0) ? (2**LEN_W - 1) : $urandom_range(0, 3);
    bad_beat[i] = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, len_r[i])) : -1;
    addr_r[i]   = $urandom;
    base_r[i]   = $urandom;
    burst_r[i]  = 2'($urandom_range(0, 2));
  endtask

  task automatic model_reset();
    own     = -1;
    ph      = 0;
    rr      = NUM_M - 1;
    exp_err = '0;
    for (int i = 0; i < NUM_M; i++) begin
      has_txn[i] = 1'b0;
      aw_done[i] = 1'b0;
    end
  endtask

  task automatic zero_inputs();
    s_awvalid = '0; s_awaddr = '0; s_awlen = '0; s_awburst = '0;
    s_wvalid  = '0; s_wdata  = '0; s_wstrb = '0; s_wlast   = '0;
    s_bready  = '0; m_awready = 1'b0; m_wready = 1'b0;
    m_bvalid  = 1'b0; m_bresp = '0; m_bid = '0;
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < NUM_M; i++) begin
      if (!has_txn[i] && (force_all || $urandom_range(0, 3) == 0)) new_txn(i);
      s_awvalid[i]              = has_txn[i] && !aw_done[i];
      s_awaddr[i*ADDR_W +: ADDR_W] = addr_r[i];
      s_awlen[i*LEN_W +: LEN_W]    = LEN_W'(len_r[i]);
      s_awburst[i*2 +: 2]          = burst_r[i];
      if (has_txn[i] && aw_done[i]) begin
        s_wvalid[i] = (sent[i] <= len_r[i]) && ($urandom_range(0, 3) != 0);
        s_wdata[i*DATA_W +: DATA_W] = base_r[i] + sent[i];
        s_wstrb[i*STRB_W +: STRB_W] = STRB_W'(base_r[i] ^ sent[i]);
        s_wlast[i] = (sent[i] == len_r[i]) ^ (int'(sent[i]) == bad_beat[i]);
      end else begin
        // Ungranted requesters throw junk W traffic that must stay isolated.
        s_wvalid[i] = ($urandom_range(0, 1) == 1);
        s_wdata[i*DATA_W +: DATA_W] = $urandom;
        s_wstrb[i*STRB_W +: STRB_W] = STRB_W'($urandom);
        s_wlast[i] = ($urandom_range(0, 1) == 1);
      end
      s_bready[i] = ($urandom_range(0, 2) != 0);
    end
    force_all = 1'b0;
    m_awready = ($urandom_range(0, 2) != 0);
    m_wready  = ($urandom_range(0, 2) != 0);
    m_bvalid  = ($urandom_range(0, 1) == 1);
    m_bresp   = 2'($urandom);
    m_bid     = 4'($urandom);
  endtask

  bit aw_hs, w_hs, b_hs;

  task automatic check_cycle();
    logic [NUM_M-1:0] oh;
    logic exp_awv, exp_wv, exp_wlast, exp_mbr;
    oh = '0; exp_awv = 1'b0; exp_wv = 1'b0; exp_wlast = 1'b0; exp_mbr = 1'b0;
    if (own >= 0) begin
      oh = NUM_M'(1) << own;
      if (ph == 0) exp_awv = s_awvalid[own];
      if (ph == 1) begin
        exp_wv    = s_wvalid[own];
        exp_wlast = (sent[own] == len_r[own]);
      end
      if (ph == 2) exp_mbr = s_bready[own];
      check_eq("grant_idx", 64'(grant_idx), 64'(own));
      if (after_rst) begin
        check_eq("first_grant_after_reset", 64'(grant_idx), 64'd0);
        after_rst = 1'b0;
      end
    end
    check_eq("busy", 64'(busy), 64'(own >= 0));
    check_eq("m_awvalid", 64'(m_awvalid), 64'(exp_awv));
    check_eq("s_awready", 64'(s_awready), 64'((own >= 0 && ph == 0 && m_awready) ? oh : '0));
    check_eq("m_wvalid", 64'(m_wvalid), 64'(exp_wv));
    check_eq("s_wready", 64'(s_wready), 64'((own >= 0 && ph == 1 && m_wready) ? oh : '0));
    check_eq("m_wlast", 64'(m_wlast), 64'(exp_wlast));
    check_eq("s_bvalid", 64'(s_bvalid), 64'((own >= 0 && ph == 2 && m_bvalid) ? oh : '0));
    check_eq("m_bready", 64'(m_bready), 64'(exp_mbr));
    check_eq("b_broadcast", 64'({s_bresp, s_bid}), 64'({m_bresp, m_bid}));
    check_eq("err_wlast", 64'(err_wlast), 64'(exp_err));
    if (exp_awv) begin
      check_eq("m_awaddr", 64'(m_awaddr), 64'(addr_r[own]));
      check_eq("m_awlen", 64'(m_awlen), 64'(len_r[own]));
      check_eq("m_awburst", 64'(m_awburst), 64'(burst_r[own]));
    end
    if (exp_wv) begin
      check_eq("m_wdata", 64'(m_wdata), 64'(base_r[own] + sent[own]));
      check_eq("m_wstrb", 64'(m_wstrb), 64'(STRB_W'(base_r[own] ^ sent[own])));
    end
    aw_hs = exp_awv && m_awready;
    w_hs  = exp_wv && m_wready;
    b_hs  = (own >= 0) && (ph == 2) && m_bvalid && exp_mbr;
  endtask

  task automatic model_step();
    if (own < 0) begin
      for (int k = 1; k <= NUM_M; k++) begin
        if (own < 0 && s_awvalid[(rr + k) % NUM_M]) begin
          own = (rr + k) % NUM_M;
          ph  = 0;
        end
      end
    end else if (ph == 0) begin
      if (aw_hs) begin
        aw_done[own] = 1'b1;
        ph = 1;
      end
    end else if (ph == 1) begin
      if (w_hs) begin
        if (s_wlast[own] != (sent[own] == len_r[own])) exp_err[own] = 1'b1;
        sent[own]++;
        if (sent[own] > len_r[own]) ph = 2;
      end
    end else if (b_hs) begin
      rr = own;
      has_txn[own] = 1'b0;
      own = -1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_valids"}, 64'({m_awvalid, m_wvalid, m_wlast, m_bready, busy}), 64'd0);
    check_eq({tag, "_s_ready"}, 64'({s_awready, s_wready, s_bvalid}), 64'd0);
    check_eq({tag, "_grant"}, 64'(grant_idx), 64'd0);
    check_eq({tag, "_err"}, 64'(err_wlast), 64'd0);
  endtask

  bit mid_done = 1'b0;

  initial begin
    force_all = 1'b0;
    after_rst = 1'b0;
    ARESETn   = 1'b0;
    zero_inputs();
    model_reset();
    #3;
    check_reset_outputs("reset");
    @(negedge ACLK);
    ARESETn = 1'b1;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge ACLK);
      drive_inputs();
      #1;
      check_cycle();
      if (!mid_done && cyc >= NCYC / 2 && ((own >= 0 && ph == 1 && sent[own] >= 1) ||
                                           cyc >= NCYC - 200)) begin
        // Abandon a transaction with an asynchronous reset mid-cycle.
        mid_done = 1'b1;
        #2 ARESETn = 1'b0;
        zero_inputs();
        #1;
        check_reset_outputs("mid_reset");
        model_reset();
        @(negedge ACLK);
        ARESETn   = 1'b1;
        force_all = 1'b1;
        after_rst = 1'b1;
      end else begin
        @(posedge ACLK);
        model_step();
      end
    end
    check_eq("mid_reset_exercised", 64'(mid_done), 64'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_wr_rr_arbiter.md
Name: axi_wr_rr_arbiter

Overview:
- Shares one downstream AXI write path (AW/W/B) between NUM_M upstream requesters, using round-robin arbitration.
- A grant is held for the whole transaction: address, all data beats, then the write response. This keeps exactly one write in flight on the slave side.
- It sits in the NoC arbiter between the initiator ports and the single slave write interface. It generates WLAST from a beat counter and flags requesters whose WLAST disagrees with it.

Parameters:
- NUM_M, 4, number of upstream requesters (2..8)
- ADDR_W, 32, address width
- DATA_W, 32, write data width
- LEN_W, 4, burst length field width (beats = AWLEN+1)

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  asynchronous active-low reset
- s_awvalid  in  NUM_M  per-requester AW valid
- s_awaddr  in  NUM_M*ADDR_W  flattened addresses; requester i occupies slice i
- s_awlen  in  NUM_M*LEN_W  flattened burst lengths
- s_awburst  in  NUM_M*2  flattened burst types
- s_awready  out  NUM_M  per-requester AW ready
- s_wvalid  in  NUM_M  per-requester W valid
- s_wdata  in  NUM_M*DATA_W  flattened write data
- s_wstrb  in  NUM_M*DATA_W/8  flattened strobes
- s_wlast  in  NUM_M  requester-supplied WLAST, checked only
- s_wready  out  NUM_M  per-requester W ready
- s_bvalid  out  NUM_M  per-requester B valid
- s_bresp  out  2  response, broadcast to all requesters
- s_bid  out  4  response ID, broadcast to all requesters
- s_bready  in  NUM_M  per-requester B ready
- m_awvalid, m_awaddr[ADDR_W], m_awlen[LEN_W], m_awburst[2]  out  downstream AW
- m_awready  in  1  downstream AW ready
- m_wvalid, m_wdata[DATA_W], m_wstrb[DATA_W/8], m_wlast  out  downstream W
- m_wready  in  1  downstream W ready
- m_bvalid  in  1, m_bresp  in  2, m_bid  in  4  downstream B
- m_bready  out  1  downstream B ready
- grant_idx  out  $clog2(NUM_M)  index of the current owner
- busy  out  1  high whenever state is not IDLE
- err_wlast  out  NUM_M  sticky WLAST-mismatch flag per requester

Behaviour:
- Reset (async, ARESETn=0):
  - state=IDLE, rr_ptr=NUM_M-1, so requester 0 has priority first.
  - beat_cnt=0, grant_idx=0, err_wlast=0.
  - All valid and ready outputs are 0.
  - Reset asserted mid-transaction abandons the transaction immediately, with no completion on either side.
- IDLE:
  - If any s_awvalid is high, select the first i with s_awvalid[i]=1, searching cyclically from rr_ptr+1.
  - Register grant_idx=i and go to ADDR. First m_awvalid appears the cycle after the request is sampled.
  - No request: stay in IDLE.
- ADDR:
  - m_aw* are combinational pass-through of the granted requester's slice.
  - s_awready[g]=m_awready; all other s_awready=0.
  - On m_awvalid&m_awready: beat_cnt<=m_awlen, go to DATA.
- DATA:
  - m_w* pass-through from the granted requester; s_wready[g]=m_wready; others 0.
  - m_wlast=(beat_cnt==0), independent of s_wlast.
  - Each W handshake with beat_cnt!=0 decrements beat_cnt.
  - A handshake with beat_cnt==0 goes to RESP.
  - On any handshake where s_wlast[g]!=m_wlast, set err_wlast[g]. It clears only on reset.
- RESP:
  - s_bvalid[g]=m_bvalid; m_bready=s_bready[g]; s_bresp=m_bresp and s_bid=m_bid, broadcast.
  - On B handshake: rr_ptr<=g, go to IDLE.
- Non-granted requesters always see s_awready=s_wready=s_bvalid=0. They may hold valid indefinitely.
- One idle cycle is inserted between a B handshake and the next grant, even if requests are pending in that cycle.
- W beats presented during ADDR are not accepted (s_wready=0 until DATA).
- beat_cnt width is LEN_W. AWLEN=2^LEN_W-1 gives 2^LEN_W beats, with no wrap.
- A requester dropping s_awvalid after grant but before handshake is a protocol violation. The grant is held until the handshake anyway.
- Downstream back-pressure (ready low) stalls in place with no timeout; valids and payloads stay stable.

Test Plan:
- Single requester: req1 AWADDR=0x1000, AWLEN=3, four beats, BRESP=0 -> m_awvalid at cycle+1, exactly 4 W handshakes, m_wlast on 4th only, s_bvalid[1] high, returns to IDLE, busy=0.
- Round-robin fairness: all four requesters hold AWLEN=0 continuously -> grant order 0,1,2,3,0 with one idle cycle between transactions.
- Isolation: req0 granted while req2 drives wvalid=1 -> s_wready[2]=0 throughout; req0's data only on m_wdata.
- WLAST check: req3 AWLEN=1 asserts s_wlast on beat 1 -> m_wlast=0 on beat 1, 1 on beat 2, err_wlast=4'b1000 sticky.
- Back-pressure: m_wready toggled 1,0,0,1 with AWLEN=1, and m_bready held low by s_bready=0 for 5 cycles -> no beat lost or duplicated, m_bvalid held, completion when s_bready rises.
- Reset mid-burst: ARESETn low during beat 2 of an AWLEN=7 burst -> all outputs 0 immediately; after release, req0 wins first arbitration.
